// File: rtl/grid_plotter.sv
// grid_plotter: sweeps the falling-sand state matrix cell by cell, maps each
// cell value to a colour and emits one VGA pixel-plot request per cycle,
// drawing every cell as a CELL_PX x CELL_PX square.
module grid_plotter #(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 40,
  parameter int CELL_PX = 3,
  parameter int X_ORG   = 65,
  parameter int Y_ORG   = 0
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic [2:0] cell_in,
  output logic [8:0] cell_x,
  output logic [7:0] cell_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       hold,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, PAINT, DONE} state_t;

  localparam logic [2:0] PX_LAST  = 3'(CELL_PX - 1);
  localparam logic [8:0] X_LAST   = 9'(GRID_W - 1);
  localparam logic [7:0] Y_LAST   = 8'(GRID_H - 1);
  localparam logic [7:0] CELL_PX8 = 8'(CELL_PX);
  localparam logic [7:0] X_ORG8   = 8'(X_ORG);
  localparam logic [7:0] Y_ORG8   = 8'(Y_ORG);

  state_t     state_q, state_d;
  logic [8:0] cell_x_q, cell_x_d;
  logic [7:0] cell_y_q, cell_y_d;
  logic [2:0] px_q, px_d;
  logic [2:0] py_q, py_d;
  logic [2:0] colour_q, colour_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic [7:0] pix_x;
  logic [6:0] pix_y;

  // Cell type to colour: wall white, Atom0 yellow, Atom1 cyan, air black,
  // and the unused encoding shows as a red marker.
  function automatic logic [2:0] colour_map(input logic [2:0] v);
    logic [2:0] c;
    case (v[1:0])
      2'b11:   c = 3'b111;
      2'b01:   c = v[2] ? 3'b011 : 3'b110;
      2'b10:   c = 3'b100;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // Screen coordinate of the current sub-pixel; products are formed at 8 bits.
  always_comb begin
    pix_x = X_ORG8 + cell_x_q[7:0] * CELL_PX8 + {5'b0, px_q};
    pix_y = 7'(Y_ORG8 + cell_y_q * CELL_PX8 + {5'b0, py_q});
  end

  // Next-state logic, counters and output drive.
  always_comb begin
    state_d      = state_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    px_d         = px_q;
    py_d         = py_q;
    colour_d     = colour_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    case (state_q)
      IDLE: begin
        cell_x_d = '0;
        cell_y_d = '0;
        px_d     = '0;
        py_d     = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        colour_d = colour_map(cell_in);
        state_d  = PAINT;
      end
      PAINT: begin
        vga_x_d      = pix_x;
        vga_y_d      = pix_y;
        vga_colour_d = colour_q;
        if (px_q != PX_LAST) begin
          px_d = px_q + 3'd1;
        end else begin
          px_d = '0;
          if (py_q != PX_LAST) begin
            py_d = py_q + 3'd1;
          end else begin
            py_d = '0;
            if (cell_x_q != X_LAST) begin
              cell_x_d = cell_x_q + 9'd1;
              state_d  = FETCH;
            end else if (cell_y_q != Y_LAST) begin
              cell_x_d = '0;
              cell_y_d = cell_y_q + 8'd1;
              state_d  = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pixel outputs are live during PAINT and otherwise hold the last plot.
    vga_plot   = (state_q == PAINT);
    vga_x      = vga_plot ? pix_x : vga_x_q;
    vga_y      = vga_plot ? pix_y : vga_y_q;
    vga_colour = vga_plot ? colour_q : vga_colour_q;
    busy       = (state_q != IDLE);
    hold       = busy;
    done       = (state_q == DONE);
    cell_x     = cell_x_q;
    cell_y     = cell_y_q;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      px_q         <= '0;
      py_q         <= '0;
      colour_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      px_q         <= px_d;
      py_q         <= py_d;
      colour_q     <= colour_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

endmodule

// File: tb/tb_grid_plotter.sv
// Directed testbench for grid_plotter: default geometry instance plus a
// CELL_PX=1, X_ORG=0 instance, each fed by a stub game.
module tb_grid_plotter;

  logic       Clock = 1'b0;
  logic       Resetn, start, start2;
  logic [2:0] cell_in, cell_in2;
  logic [8:0] cell_x, cell_x2;
  logic [7:0] cell_y, cell_y2;
  logic [7:0] vga_x, vga_x2;
  logic [6:0] vga_y, vga_y2;
  logic [2:0] vga_colour, vga_colour2;
  logic       vga_plot, vga_plot2, busy, busy2, hold, hold2, done, done2;

  always #5 Clock = ~Clock;

  grid_plotter dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .cell_in(cell_in),
    .cell_x(cell_x), .cell_y(cell_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .hold(hold), .done(done)
  );

  grid_plotter #(.CELL_PX(1), .X_ORG(0)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .start(start2), .cell_in(cell_in2),
    .cell_x(cell_x2), .cell_y(cell_y2), .vga_x(vga_x2), .vga_y(vga_y2),
    .vga_colour(vga_colour2), .vga_plot(vga_plot2), .busy(busy2),
    .hold(hold2), .done(done2)
  );

  int cyc = 0;
  int n0 = 0;
  int mode = 0;
  int errors = 0;
  int checks = 0;

  // Cycle counter; read on the falling edge, so it names the current cycle.
  always @(posedge Clock) cyc <= cyc + 1;

  // Stub game contents: 0 = well (walls left/right/bottom), 1 = one Atom1
  // at (6,1), 2 = undefined encoding everywhere.
  function automatic logic [2:0] stub(input int m, input int x, input int y);
    if (m == 0) return (x == 0 || x == 9 || y == 39) ? 3'b011 : 3'b000;
    if (m == 1) return (x == 6 && y == 1) ? 3'b101 : 3'b000;
    return 3'b010;
  endfunction

  function automatic logic [2:0] cmap(input logic [2:0] v);
    if (v[1:0] == 2'b11) return 3'b111;
    if (v[1:0] == 2'b01) return v[2] ? 3'b011 : 3'b110;
    if (v[1:0] == 2'b10) return 3'b100;
    return 3'b000;
  endfunction

  // Expected k-th pixel of a default-geometry sweep.
  function automatic int exp_x(input int k);
    return 65 + ((k / 9) % 10) * 3 + (k % 9) % 3;
  endfunction
  function automatic int exp_y(input int k);
    return ((k / 9) / 10) * 3 + (k % 9) / 3;
  endfunction

  always_comb cell_in  = stub(mode, int'(cell_x), int'(cell_y));
  always_comb cell_in2 = ((int'(cell_x2) + int'(cell_y2)) % 2 == 1) ? 3'b011 : 3'b000;

  // Monitor for the default instance.
  int plots = 0, pos_bad = 0, col_bad = 0, dones = 0, k = 0;
  int c011_in = 0, c011_all = 0, c100 = 0;
  int first_plot = 0, last_plot = 0, done_rel = 0;
  logic [2:0] c_corner = 3'b101, c_air = 3'b101;

  always @(negedge Clock) begin
    if (!busy) k <= 0;
    else if (vga_plot) k <= k + 1;
    if (vga_plot) begin
      plots <= plots + 1;
      if (vga_x != exp_x(k) || vga_y != exp_y(k)) pos_bad <= pos_bad + 1;
      if (vga_colour != cmap(stub(mode, (k / 9) % 10, (k / 9) / 10))) col_bad <= col_bad + 1;
      if (vga_x == 66 && vga_y == 1) c_corner <= vga_colour;
      if (vga_x == 69 && vga_y == 4) c_air <= vga_colour;
      if (vga_colour == 3'b011) c011_all <= c011_all + 1;
      if (vga_colour == 3'b011 && vga_x >= 83 && vga_x <= 85 && vga_y >= 3 && vga_y <= 5)
        c011_in <= c011_in + 1;
      if (vga_colour == 3'b100) c100 <= c100 + 1;
      if (k == 0) first_plot <= cyc - n0;
      last_plot <= cyc - n0;
    end
    if (done) begin
      dones    <= dones + 1;
      done_rel <= cyc - n0;
    end
  end

  // Monitor for the CELL_PX=1 instance: pixel k is cell (k%10, k/10).
  int plots2 = 0, pos_bad2 = 0, col_bad2 = 0, k2 = 0;
  int first_plot2 = 0, last_plot2 = 0, done_rel2 = 0;

  always @(negedge Clock) begin
    if (!busy2) k2 <= 0;
    else if (vga_plot2) k2 <= k2 + 1;
    if (vga_plot2) begin
      plots2 <= plots2 + 1;
      if (vga_x2 != (k2 % 10) || vga_y2 != (k2 / 10)) pos_bad2 <= pos_bad2 + 1;
      if (vga_colour2 != ((((k2 % 10) + (k2 / 10)) % 2 == 1) ? 3'b111 : 3'b000))
        col_bad2 <= col_bad2 + 1;
      if (k2 == 0) first_plot2 <= cyc - n0;
      last_plot2 <= cyc - n0;
    end
    if (done2) done_rel2 <= cyc - n0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the falling edge of cycle n0+r.
  task automatic go_rel(input int r);
    while (cyc < n0 + r) @(negedge Clock);
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    n0 = cyc;
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  int p0, d0, cb0, pb0, c0, a0, h0;

  initial begin
    Resetn = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_plot", vga_plot, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", hold, 0);
    check("rst_cell_x", cell_x, 0);
    check("rst_cell_y", cell_y, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    check("idle_busy", busy, 0);

    // Full sweep of the seed-like well.
    mode = 0;
    p0 = plots; d0 = dones;
    pulse_start();
    check("a_busy_n1", busy, 1);
    check("a_hold_n1", hold, 1);
    check("a_plot_n1", vga_plot, 0);
    go_rel(2);
    check("a_plot_n2", vga_plot, 1);
    go_rel(4001);
    check("a_done_n4001", done, 1);
    go_rel(4002);
    check("a_busy_n4002", busy, 0);
    check("a_done_n4002", done, 0);
    check("a_hold_x", vga_x, 94);
    check("a_hold_y", vga_y, 119);
    check("a_hold_colour", vga_colour, 3'b111);
    check("a_plots", plots - p0, 3600);
    check("a_dones", dones - d0, 1);
    check("a_first_plot", first_plot, 2);
    check("a_last_plot", last_plot, 4000);
    check("a_done_rel", done_rel, 4001);
    check("a_corner_colour", c_corner, 3'b111);
    check("a_air_colour", c_air, 3'b000);
    check("a_col_bad", col_bad, 0);
    check("a_pos_bad", pos_bad, 0);

    // start held high: back-to-back sweeps with a single IDLE cycle.
    d0 = dones; p0 = plots;
    @(negedge Clock);
    n0 = cyc;
    start = 1'b1;
    go_rel(4001);
    check("b_done1", done, 1);
    go_rel(4002);
    check("b_idle_gap", busy, 0);
    go_rel(4003);
    check("b_refetch", busy, 1);
    go_rel(5000);
    start = 1'b0;
    go_rel(8003);
    check("b_done2", done, 1);
    go_rel(8004);
    check("b_busy_end", busy, 0);
    go_rel(8100);
    check("b_dones", dones - d0, 2);
    check("b_plots", plots - p0, 7200);

    // Reset in the middle of a sweep.
    d0 = dones; p0 = plots;
    pulse_start();
    go_rel(1000);
    Resetn = 1'b0;
    go_rel(1001);
    Resetn = 1'b1;
    check("c_plot_after_rst", vga_plot, 0);
    check("c_busy_after_rst", busy, 0);
    check("c_hold_after_rst", hold, 0);
    check("c_done_after_rst", done, 0);
    check("c_cell_x_after_rst", cell_x, 0);
    check("c_vga_x_after_rst", vga_x, 0);
    go_rel(4100);
    check("c_no_done", dones - d0, 0);
    check("c_plots", plots - p0, 900);
    check("c_busy_idle", busy, 0);

    // Restart from (0,0) with a single Atom1 at (6,1).
    mode = 1;
    p0 = plots; cb0 = col_bad; pb0 = pos_bad; c0 = c011_in; a0 = c011_all;
    pulse_start();
    check("d_cell_x0", cell_x, 0);
    check("d_cell_y0", cell_y, 0);
    go_rel(2);
    check("d_first_x", vga_x, 65);
    check("d_first_y", vga_y, 0);
    go_rel(4002);
    check("d_plots", plots - p0, 3600);
    check("d_atom1_in_square", c011_in - c0, 9);
    check("d_atom1_total", c011_all - a0, 9);
    check("d_col_bad", col_bad - cb0, 0);
    check("d_pos_bad", pos_bad - pb0, 0);

    // Undefined encoding everywhere shows as red.
    mode = 2;
    h0 = c100; cb0 = col_bad;
    pulse_start();
    go_rel(4002);
    check("e_red_plots", c100 - h0, 3600);
    check("e_col_bad", col_bad - cb0, 0);

    // CELL_PX=1, X_ORG=0 instance: two cycles per cell.
    @(negedge Clock);
    n0 = cyc;
    start2 = 1'b1;
    @(negedge Clock);
    start2 = 1'b0;
    check("f_busy_n1", busy2, 1);
    go_rel(2);
    check("f_plot_n2", vga_plot2, 1);
    go_rel(3);
    check("f_plot_n3", vga_plot2, 0);
    go_rel(4);
    check("f_plot_n4", vga_plot2, 1);
    check("f_x_n4", vga_x2, 1);
    go_rel(801);
    check("f_done_n801", done2, 1);
    go_rel(802);
    check("f_busy_n802", busy2, 0);
    check("f_plots", plots2, 400);
    check("f_first_plot", first_plot2, 2);
    check("f_last_plot", last_plot2, 800);
    check("f_done_rel", done_rel2, 801);
    check("f_pos_bad", pos_bad2, 0);
    check("f_col_bad", col_bad2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
